// File: rtl/reg_value_entry_pkg.sv
// rtl/reg_value_entry_pkg.sv - shared encodings, widths and helpers for the operator value-entry path
package reg_value_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         MAG_W     = 10;
    localparam int         CNT_W     = 2;
    localparam int         DATA_W    = 32;

    // Zero-extend before negating so -0 comes out as 0 and small magnitudes
    // become proper 32-bit two's-complement words.
    function automatic logic [DATA_W-1:0] signed_word(input logic neg,
                                                      input logic [MAG_W-1:0] mag);
        logic [DATA_W-1:0] ext;
        ext = {{(DATA_W-MAG_W){1'b0}}, mag};
        return neg ? (~ext + {{(DATA_W-1){1'b0}}, 1'b1}) : ext;
    endfunction

endpackage

// File: rtl/reg_value_entry_key_debounce.sv
// rtl/reg_value_entry_key_debounce.sv - key synchronizer, optional debounce and rising-edge pulse
//
// Purpose: turns one raw active-high push-button into a single one-cycle pulse
//          per press. Optional stable-high counter when DEBOUNCE_EN is defined.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-low
//   key_i    raw button level
//   pulse_o  one-cycle pulse on each accepted press
// Macro: DEBOUNCE_EN (parameter DEBOUNCE_CYCLES exists only when defined)
module key_debounce
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 250000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;
    logic level;

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          stable_q;

    // Level rises on the DEBOUNCE_CYCLES-th consecutive high sample and
    // drops on the first low sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (!sync2_q) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign level = stable_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= level;
            pulse_q <= level & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/reg_value_entry.sv
// rtl/reg_value_entry.sv - builds a signed decimal value from BCD digits and issues one register write
//
// Purpose: operator-input path of the debug display. Digits accumulate into a
//          magnitude, a sign key toggles polarity, commit issues (rd, value)
//          to the register file through a valid/ready handshake.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   digit_in[3:0], rd_in[4:0]         switch inputs
//   key_digit, key_sign, key_commit   raw active-high buttons
//   wr_valid, wr_ready                write handshake
//   wr_rd[4:0], wr_val[31:0]          write destination and two's-complement data
//   entry_mag[9:0], entry_neg         current entry for display echo
//   entry_cnt[1:0]                    digits accepted so far
//   err                               sticky error
// Macro: DEBOUNCE_EN enables per-key debounce counters (DEBOUNCE_CYCLES)
module reg_value_entry
    import reg_value_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 3
`ifdef DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 250000
`endif
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_in,
    input  logic [4:0]  rd_in,
    input  logic        key_digit,
    input  logic        key_sign,
    input  logic        key_commit,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [4:0]  wr_rd,
    output logic [31:0] wr_val,
    output logic [9:0]  entry_mag,
    output logic        entry_neg,
    output logic [1:0]  entry_cnt,
    output logic        err
);

    logic [2:0] keys;
    logic [2:0] key_pulse;

    // bit 0 digit, bit 1 sign, bit 2 commit
    assign keys = {key_commit, key_sign, key_digit};

    for (genvar g = 0; g < 3; g++) begin : g_key
`ifdef DEBOUNCE_EN
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk     (clk),
            .rst     (rst),
            .key_i   (keys[g]),
            .pulse_o (key_pulse[g])
        );
`else
        key_debounce u_key (
            .clk     (clk),
            .rst     (rst),
            .key_i   (keys[g]),
            .pulse_o (key_pulse[g])
        );
`endif
    end

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [4:0]         wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0]  wr_val_q, wr_val_d;

    logic commit_p;
    logic digit_p;
    logic sign_p;
    logic digit_ok;

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wr_rd_d  = wr_rd_q;
        wr_val_d = wr_val_q;

        // Same-cycle priority: commit over digit over sign.
        commit_p = key_pulse[2];
        digit_p  = key_pulse[0] & ~key_pulse[2];
        sign_p   = key_pulse[1] & ~key_pulse[2] & ~key_pulse[0];
        digit_ok = (digit_in <= DIGIT_MAX);

        unique case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (commit_p) begin
                    if (rd_in == REG_ZERO) begin
                        err_d   = 1'b1;
                        mag_d   = '0;
                        neg_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        wr_rd_d  = rd_in;
                        wr_val_d = signed_word(neg_q, mag_q);
                        state_d  = ST_WRITE;
                    end
                end else if (digit_p) begin
                    if (!digit_ok) begin
                        err_d = 1'b1;
                    end else if (state_q == ST_IDLE) begin
                        mag_d   = MAG_W'(digit_in);
                        cnt_d   = CNT_W'(1);
                        err_d   = 1'b0;
                        state_d = ST_ENTRY;
                    end else if (cnt_q >= CNT_W'(MAX_DIGITS)) begin
                        err_d = 1'b1;
                    end else begin
                        mag_d = mag_q * MAG_W'(10) + MAG_W'(digit_in);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sign_p) begin
                    neg_d = ~neg_q;
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wr_rd_q  <= '0;
            wr_val_q <= '0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wr_rd_q  <= wr_rd_d;
            wr_val_q <= wr_val_d;
        end
    end

    assign wr_valid  = (state_q == ST_WRITE);
    assign wr_rd     = wr_rd_q;
    assign wr_val    = wr_val_q;
    assign entry_mag = mag_q;
    assign entry_neg = neg_q;
    assign entry_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_value_entry.sv
// tb/tb_reg_value_entry.sv - self-checking bench for reg_value_entry against a behavioural entry model
module tb_reg_value_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit_in = '0;
    logic [4:0]  rd_in = '0;
    logic        key_digit = 1'b0;
    logic        key_sign = 1'b0;
    logic        key_commit = 1'b0;
    logic        wr_ready = 1'b1;
    logic        wr_valid;
    logic [4:0]  wr_rd;
    logic [31:0] wr_val;
    logic [9:0]  entry_mag;
    logic        entry_neg;
    logic [1:0]  entry_cnt;
    logic        err;

    always #5 clk = ~clk;

`ifdef DEBOUNCE_EN
    reg_value_entry #(.MAX_DIGITS(3), .DEBOUNCE_CYCLES(4)) dut (
`else
    reg_value_entry #(.MAX_DIGITS(3)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .digit_in   (digit_in),
        .rd_in      (rd_in),
        .key_digit  (key_digit),
        .key_sign   (key_sign),
        .key_commit (key_commit),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_rd      (wr_rd),
        .wr_val     (wr_val),
        .entry_mag  (entry_mag),
        .entry_neg  (entry_neg),
        .entry_cnt  (entry_cnt),
        .err        (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: decimal value as plain integers.
    int m_mag = 0;
    bit m_neg = 1'b0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_entry();
        return {50'd0, m_mag[9:0], m_neg, m_cnt[1:0], m_err};
    endfunction

    function automatic logic [63:0] dut_entry();
        return {50'd0, entry_mag, entry_neg, entry_cnt, err};
    endfunction

    task automatic model_clear();
        m_mag = 0;
        m_neg = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_digit(input int d);
        if (d > 9) m_err = 1'b1;
        else if (m_cnt == 0) begin
            m_mag = d;
            m_cnt = 1;
            m_err = 1'b0;
        end else if (m_cnt == 3) m_err = 1'b1;
        else begin
            m_mag = m_mag * 10 + d;
            m_cnt++;
        end
    endtask

    task automatic press(input bit kd, input bit ks, input int hold);
        key_digit = kd;
        key_sign  = ks;
        repeat (hold) @(negedge clk);
        key_digit = 1'b0;
        key_sign  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_digit(input int d);
        digit_in = 4'(d);
        press(1'b1, 1'b0, 8);
        model_digit(d);
        check("digit", dut_entry(), model_entry());
    endtask

    task automatic do_sign();
        press(1'b0, 1'b1, 8);
        m_neg = !m_neg;
        check("sign", dut_entry(), model_entry());
    endtask

    task automatic do_digit_and_sign(input int d);
        digit_in = 4'(d);
        press(1'b1, 1'b1, 8);
        model_digit(d);
        check("prio_digit_over_sign", dut_entry(), model_entry());
    endtask

    task automatic do_commit(input logic [4:0] rd, input int stall);
        int          v;
        int          extra;
        bit          seen;
        logic [31:0] exp_val;
        v       = m_neg ? -m_mag : m_mag;
        exp_val = v;
        rd_in      = rd;
        wr_ready   = 1'b0;
        key_commit = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (i == 9) key_commit = 1'b0;
            if (wr_valid) seen = 1'b1;
        end
        key_commit = 1'b0;
        check("wr_valid_seen", 64'(seen), 64'(rd != 5'd0));
        if (rd != 5'd0) begin
            if (seen) begin
                check("wr_rd", 64'(wr_rd), 64'(rd));
                check("wr_val", 64'(wr_val), 64'(exp_val));
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    if (stall >= 12) begin
                        key_digit = (k < 8);
                        key_sign  = (k >= 1 && k < 8);
                    end
                    check("stall_hold", {14'd0, wr_valid, wr_rd, wr_val, entry_mag},
                          {14'd0, 1'b1, rd, exp_val, m_mag[9:0]});
                end
                key_digit = 1'b0;
                key_sign  = 1'b0;
                wr_ready  = 1'b1;
                @(negedge clk);
                check("wr_valid_drop", 64'(wr_valid), 64'd0);
                extra = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (wr_valid) extra++;
                end
                check("single_accept", 64'(extra), 64'd0);
            end
            model_clear();
        end else begin
            m_err = 1'b1;
            model_clear();
        end
        wr_ready = 1'b1;
        check("post_commit", dut_entry(), model_entry());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;

        repeat (4) @(negedge clk);
        check("reset_outputs",
              {12'd0, wr_valid, wr_rd, wr_val, entry_mag, entry_neg, entry_cnt, err}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: +123 to r5
        do_digit(1); do_digit(2); do_digit(3);
        do_commit(5'd5, 0);

        // 2: -45 to r7
        do_digit(4); do_digit(5); do_sign();
        check("neg_before_commit", 64'(entry_neg), 64'd1);
        do_commit(5'd7, 0);

        // 3: fourth digit rejected
        do_digit(9); do_digit(9); do_digit(9); do_digit(1);
        check("overflow_err", {54'd0, err, entry_cnt, 10'd0} | 64'(entry_mag), {54'd0, 1'b1, 2'd3, 10'd999});
        do_commit(5'd2, 0);

        // 4: bad BCD digit, then commit to r0
        do_digit(12);
        do_commit(5'd0, 0);

        // commit with nothing entered writes zero; -0 writes zero
        do_commit(5'd4, 0);
        do_sign();
        do_commit(5'd6, 0);

        // 5: long stall with keys pressed during WRITE
        do_digit(6); do_digit(7);
        do_commit(5'd9, 14);

        do_digit_and_sign(3);
        do_sign();

        // 6: reset mid-handshake
        rd_in      = 5'd3;
        wr_ready   = 1'b0;
        key_commit = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (wr_valid) seen = 1'b1;
        end
        key_commit = 1'b0;
        check("rst_test_valid_seen", 64'(seen), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_handshake", {48'd0, wr_valid, entry_mag, entry_neg, entry_cnt, err}, 64'd0);
        rst      = 1'b1;
        wr_ready = 1'b1;
        model_clear();
        m_err = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_late_write", 64'(wr_valid), 64'd0);
        digit_in = 4'd5;
        press(1'b1, 1'b0, 20);
        model_digit(5);
        check("held_key_one_digit", dut_entry(), model_entry());

        // randomized operations
        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) do_digit($urandom_range(0, 11));
            else if (r <= 7) do_sign();
            else if (r == 8) do_commit(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                                       $urandom_range(0, 15));
            else do_digit_and_sign($urandom_range(0, 9));
        end
        do_commit(5'd31, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
